// File: rtl/axi_burst_writer.sv
// Drains full bursts from an asynchronous-read FIFO as AXI4 INCR write bursts
// to a linearly advancing, burst-aligned address; one transaction outstanding.
module axi_burst_writer #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned LGFLEN  = 4,
    parameter int unsigned LGBURST = 3,
    parameter int unsigned NBW     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [AW-1:0]        i_base_addr,
    input  logic [NBW-1:0]       i_nbursts,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_fifo_rd,
    input  logic [DW-1:0]        i_fifo_data,
    input  logic                 i_fifo_empty,
    input  logic [LGFLEN:0]      i_fifo_fill,
    output logic                 M_AXI_AWVALID,
    input  logic                 M_AXI_AWREADY,
    output logic [AW-1:0]        M_AXI_AWADDR,
    output logic [7:0]           M_AXI_AWLEN,
    output logic [2:0]           M_AXI_AWSIZE,
    output logic [1:0]           M_AXI_AWBURST,
    output logic                 M_AXI_WVALID,
    input  logic                 M_AXI_WREADY,
    output logic [DW-1:0]        M_AXI_WDATA,
    output logic [DW/8-1:0]      M_AXI_WSTRB,
    output logic                 M_AXI_WLAST,
    input  logic                 M_AXI_BVALID,
    output logic                 M_AXI_BREADY,
    input  logic [1:0]           M_AXI_BRESP
);
    localparam int unsigned BURST_LEN   = 1 << LGBURST;
    localparam int unsigned BEAT_BYTES  = DW / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int unsigned FILL_W      = LGFLEN + 1;
    localparam logic [AW-1:0] ADDR_STEP  = AW'(BURST_BYTES);
    localparam logic [AW-1:0] ALIGN_MASK = ~(ADDR_STEP - AW'(1));
    localparam logic [LGBURST-1:0] LAST_BEAT = LGBURST'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FILL,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [NBW-1:0]     remaining_q, remaining_d;
    logic [LGBURST-1:0] beat_q, beat_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               w_hs;
    logic               last_beat;
    logic               unused_bresp;

    assign unused_bresp = M_AXI_BRESP[0];
    assign last_beat    = (beat_q == LAST_BEAT);
    assign w_hs         = (state_q == S_DATA) && !i_fifo_empty && M_AXI_WREADY;

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beat_d      = beat_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d      = i_base_addr & ALIGN_MASK;
                    remaining_d = i_nbursts;
                    err_d       = 1'b0;
                    if (i_nbursts == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_FILL;
                    end
                end
            end
            S_WAIT_FILL: begin
                if (i_fifo_fill >= FILL_W'(BURST_LEN)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (M_AXI_AWREADY) begin
                    state_d = S_DATA;
                    beat_d  = '0;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + LGBURST'(1);
                    if (last_beat) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP[1]) begin
                        err_d = 1'b1;
                    end
                    remaining_d = remaining_q - NBW'(1);
                    if (remaining_q == NBW'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_STEP;
                        state_d = S_WAIT_FILL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Outputs decoded from registered state; WDATA/WVALID track the FIFO head
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign o_fifo_rd     = w_hs;
    assign M_AXI_AWVALID = (state_q == S_ADDR);
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(BEAT_BYTES));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WVALID  = (state_q == S_DATA) && !i_fifo_empty;
    assign M_AXI_WDATA   = i_fifo_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (state_q == S_DATA) && last_beat;
    assign M_AXI_BREADY  = (state_q == S_RESP);

endmodule

// File: tb/tb_axi_burst_writer.sv
// Scoreboard bench for axi_burst_writer: FIFO + AXI slave model, expected
// AW/W/done queues filled by stimulus and drained by an independent monitor.
module tb_axi_burst_writer;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic [15:0] i_nbursts;
    logic        o_busy, o_done, o_err, o_fifo_rd;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic [4:0]  fifo_fill;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;

    axi_burst_writer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_nbursts(i_nbursts),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_fifo_rd(o_fifo_rd),
        .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty), .i_fifo_fill(fifo_fill),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr),
        .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata),
        .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] fifo[$];
    logic [31:0] src[$];
    logic [1:0]  bresp_q[$];
    logic [31:0] exp_aw[$];
    logic [32:0] exp_w[$];
    logic        exp_done[$];
    int          src_gap = 0;
    bit          bp = 1'b0;
    logic [31:0] src_word = 0;
    logic [31:0] exp_word = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event with no expectation pending", name);
    endtask

    // Upstream FIFO (depth 16) and AXI slave model; updates just after each edge
    initial begin
        bit pop_s, bhs_s, wl_s;
        int gap_cnt = 0;
        int b_pending = 0;
        int b_dly = 0;
        logic [31:0] dummy;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        fifo_data = '0; fifo_empty = 1'b1; fifo_fill = '0;
        forever begin
            @(negedge i_clk);
            pop_s = o_fifo_rd;
            bhs_s = bvalid && bready;
            wl_s  = wvalid && wready && wlast;
            @(posedge i_clk);
            #1;
            if (i_reset) begin
                fifo.delete(); src.delete(); bresp_q.delete();
                bvalid = 1'b0; b_pending = 0; b_dly = 0; gap_cnt = 0;
                awready = 1'b0; wready = 1'b0;
            end else begin
                if (pop_s && fifo.size() > 0) dummy = fifo.pop_front();
                if (src.size() > 0 && fifo.size() < 16) begin
                    if (gap_cnt == 0) begin
                        fifo.push_back(src.pop_front());
                        gap_cnt = src_gap;
                    end else gap_cnt--;
                end
                if (bhs_s) bvalid = 1'b0;
                if (wl_s) b_pending++;
                if (!bvalid && b_pending > 0) begin
                    if (b_dly == 0) begin
                        bvalid = 1'b1;
                        bresp = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                        b_pending--;
                        b_dly = bp ? int'($urandom_range(0, 5)) : 0;
                    end else b_dly--;
                end
                awready = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
                wready  = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            end
            fifo_fill  = 5'(fifo.size());
            fifo_empty = (fifo.size() == 0);
            fifo_data  = (fifo.size() > 0) ? fifo[0] : 32'h0;
        end
    end

    // Monitor: pops expectations on each handshake and checks stall stability
    initial begin
        bit aw_st = 0, w_st = 0, aw_prev = 0;
        logic [31:0] aw_hold;
        logic [32:0] w_hold;
        logic [31:0] ea;
        logic [32:0] ew;
        logic        ed;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                aw_st = 0; w_st = 0; aw_prev = 0;
            end else begin
                if (aw_st) check("aw_stable", {awvalid, awaddr}, {1'b1, aw_hold});
                if (w_st)  check("w_stable", {wvalid, wlast, wdata}, {1'b1, w_hold});
                if (awvalid && !aw_prev) check("aw_fill_ge8", 64'(fifo_fill >= 5'd8), 64'd1);
                if (wvalid) check("w_nonempty", 64'(fifo_empty), 64'd0);
                if (awvalid && awready) begin
                    if (exp_aw.size() == 0) fail("aw_unexpected");
                    else begin
                        ea = exp_aw.pop_front();
                        check("aw_addr", 64'(awaddr), 64'(ea));
                        check("aw_ctl", {awlen, awsize, awburst}, {8'd7, 3'd2, 2'b01});
                    end
                end
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) fail("w_unexpected");
                    else begin
                        ew = exp_w.pop_front();
                        check("w_beat", {wlast, wdata, wstrb}, {ew, 4'hF});
                    end
                end
                if (o_done) begin
                    if (exp_done.size() == 0) fail("done_unexpected");
                    else begin
                        ed = exp_done.pop_front();
                        check("done_err_busy", {o_err, o_busy}, {ed, 1'b0});
                    end
                end
                aw_st = awvalid && !awready; aw_hold = awaddr;
                w_st  = wvalid && !wready;   w_hold  = {wlast, wdata};
                aw_prev = awvalid;
            end
        end
    end

    task automatic load(input int n, input int gap);
        @(negedge i_clk); #2;
        src_gap = gap;
        for (int i = 0; i < n; i++) begin
            src.push_back(src_word);
            src_word++;
        end
    endtask

    task automatic wait_fifo(input int n);
        int k = 0;
        while (fifo.size() != n && k < 200) begin @(negedge i_clk); k++; end
        if (k >= 200) check("fifo_preload_timeout", 64'(fifo.size()), 64'(n));
    endtask

    task automatic exp_cmd(input logic [31:0] aligned, input int nb, input logic err);
        logic [31:0] a = aligned;
        for (int b = 0; b < nb; b++) begin
            exp_aw.push_back(a);
            a = a + 32'h20;
            for (int i = 0; i < 8; i++) begin
                exp_w.push_back({(i == 7), exp_word});
                exp_word++;
            end
        end
        exp_done.push_back(err);
    endtask

    task automatic start_cmd(input logic [31:0] base, input logic [15:0] nb);
        @(negedge i_clk); #2;
        i_start = 1'b1; i_base_addr = base; i_nbursts = nb;
        @(negedge i_clk); #2;
        i_start = 1'b0; i_base_addr = '0; i_nbursts = '0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((exp_done.size() != 0 || o_busy) && k < budget) begin @(negedge i_clk); k++; end
        if (k >= budget) check("idle_timeout", 64'(exp_done.size()), 64'd0);
        @(negedge i_clk);
    endtask

    initial begin
        int k;
        i_reset = 1'b1; i_start = 1'b0; i_base_addr = '0; i_nbursts = '0;
        repeat (3) @(negedge i_clk);
        check("reset_outputs", {o_busy, o_done, o_err, o_fifo_rd, awvalid, wvalid, bready},
              7'd0);
        check("reset_addr", 64'(awaddr), 64'd0);
        #3 i_reset = 1'b0;

        // Basic: 16 words preloaded, two bursts at 0x1000, latency to AWVALID
        load(16, 0);
        wait_fifo(16);
        exp_cmd(32'h1000, 2, 1'b0);
        start_cmd(32'h1000, 16'd2);
        check("awvalid_early", 64'(awvalid), 64'd0);
        @(negedge i_clk);
        check("start_to_awvalid", 64'(awvalid), 64'd1);
        wait_idle(200);
        check("basic_fifo_empty", 64'(fifo.size()), 64'd0);

        // Slow upstream: one word every third cycle
        load(16, 2);
        exp_cmd(32'h2000, 2, 1'b0);
        start_cmd(32'h2000, 16'd2);
        wait_idle(400);

        // Backpressure on AW/W/B
        bp = 1'b1;
        load(24, 0);
        exp_cmd(32'h3000, 3, 1'b0);
        start_cmd(32'h3010, 16'd3);
        wait_idle(2000);
        bp = 1'b0;

        // Alignment and address wrap
        load(16, 0);
        wait_fifo(16);
        exp_cmd(32'hFFFF_FFE0, 2, 1'b0);
        start_cmd(32'hFFFF_FFF4, 16'd2);
        wait_idle(200);

        // SLVERR on the first of three bursts: all complete, error sticks
        load(24, 0);
        @(negedge i_clk); #2;
        bresp_q.push_back(2'b10); bresp_q.push_back(2'b00); bresp_q.push_back(2'b00);
        exp_cmd(32'h4000, 3, 1'b1);
        start_cmd(32'h4000, 16'd3);
        wait_idle(400);
        check("err_sticky_idle", 64'(o_err), 64'd1);

        // nbursts==0 clears error, done next cycle, no AXI traffic
        exp_done.push_back(1'b0);
        start_cmd(32'h5000, 16'd0);
        check("zero_done_pulse", {o_done, o_busy, o_err}, 3'b100);
        wait_idle(20);
        check("zero_no_traffic", 64'(exp_aw.size() + exp_w.size()), 64'd0);

        // Start while busy is ignored
        load(16, 0);
        wait_fifo(16);
        exp_cmd(32'h4400, 2, 1'b0);
        start_cmd(32'h4400, 16'd2);
        @(negedge i_clk);
        start_cmd(32'h9000, 16'd5);
        wait_idle(200);

        // Asynchronous reset in the middle of a DATA phase
        load(16, 0);
        wait_fifo(16);
        exp_cmd(32'h6000, 2, 1'b0);
        start_cmd(32'h6000, 16'd2);
        k = 0;
        while (!wvalid && k < 50) begin @(negedge i_clk); k++; end
        if (k >= 50) check("reach_data_timeout", 64'(wvalid), 64'd1);
        repeat (2) @(negedge i_clk);
        #3 i_reset = 1'b1;
        #1 check("reset_mid_data", {awvalid, wvalid, bready, o_busy, o_fifo_rd}, 5'd0);
        repeat (2) @(negedge i_clk);
        exp_aw.delete(); exp_w.delete(); exp_done.delete();
        exp_word = src_word;
        #3 i_reset = 1'b0;
        check("post_reset_idle", {o_busy, o_done, o_err}, 3'd0);

        // Fresh command after reset
        load(8, 0);
        wait_fifo(8);
        exp_cmd(32'h0500, 1, 1'b0);
        start_cmd(32'h0517, 16'd1);
        wait_idle(200);

        check("aw_left", 64'(exp_aw.size()), 64'd0);
        check("w_left", 64'(exp_w.size()), 64'd0);
        check("done_left", 64'(exp_done.size()), 64'd0);
        check("final_fifo_empty", 64'(fifo.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_burst_writer.md
# axi_burst_writer

Downstream drain stage for the synchronous data FIFO: watches the FIFO fill level, and whenever a full burst is buffered, pops it out as one AXI4 INCR write burst to a linearly advancing address. It sits between the FIFO's read port and an AXI4 master write port. It runs a programmed number of bursts per start command, keeps one transaction outstanding, and reports completion and error status.

## Interface
- DW, 32: AXI data width and FIFO word width; power of two, 8..1024
- AW, 32: AXI address width
- LGFLEN, 4: log2 of upstream FIFO depth; sizes the fill input
- LGBURST, 3: log2 of beats per burst; BURST_LEN = 1<<LGBURST, must be ≤ 1<<LGFLEN and ≤ 256
- NBW, 16: width of burst-count command
- i_clk  in  1  clock; all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle command strobe; accepted only in IDLE
- i_base_addr  in  AW  start byte address; low log2(BURST_LEN*DW/8) bits forced to zero at capture
- i_nbursts  in  NBW  number of bursts to issue
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse when the command completes
- o_err  out  1  sticky; set on any SLVERR/DECERR response; cleared on accepted i_start
- o_fifo_rd  out  1  FIFO pop strobe
- i_fifo_data  in  DW  FIFO head word; combinational (asynchronous-read FIFO)
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_fill  in  LGFLEN+1  FIFO occupancy
- M_AXI_AWVALID out 1; M_AXI_AWREADY in 1; M_AXI_AWADDR out AW; M_AXI_AWLEN out 8 (= BURST_LEN-1); M_AXI_AWSIZE out 3 (= log2(DW/8)); M_AXI_AWBURST out 2 (= 2'b01)
- M_AXI_WVALID out 1; M_AXI_WREADY in 1; M_AXI_WDATA out DW (= i_fifo_data); M_AXI_WSTRB out DW/8 (all ones); M_AXI_WLAST out 1
- M_AXI_BVALID in 1; M_AXI_BREADY out 1; M_AXI_BRESP in 2

## Operation
- States: IDLE, WAIT_FILL, ADDR, DATA, RESP.
- IDLE: on i_start, capture the aligned address, load the remaining count from i_nbursts, and clear o_err. If i_nbursts==0, stay in IDLE and pulse o_done the next cycle. Otherwise go to WAIT_FILL.
- WAIT_FILL: when i_fifo_fill ≥ BURST_LEN, go to ADDR.
- ADDR: AWVALID=1 with a stable address; on AWREADY, go to DATA and clear the beat counter.
- DATA: WVALID = !i_fifo_empty; o_fifo_rd = WVALID && WREADY.
  - Beat counter is LGBURST bits; WLAST = (beat counter == BURST_LEN-1).
  - On the handshake with WLAST, go to RESP.
- RESP: BREADY=1. On BVALID:
  - If BRESP[1], set o_err.
  - Decrement the remaining count.
  - If remaining was 1: go to IDLE and pulse o_done.
  - Else: address += BURST_LEN*DW/8 (mod 2^AW) and go to WAIT_FILL.
- 4 KB rule: a burst never crosses a 4 KB boundary. Guaranteed by the forced alignment, given BURST_LEN*DW/8 ≤ 4096.
- i_start outside IDLE is ignored.
- Errors do not abort the command; all bursts are still issued.

## Timing
- Reset values: state IDLE; o_busy, o_done, o_err, o_fifo_rd, AWVALID, WVALID, BREADY = 0; address and counters = 0.
- Asynchronous reset mid-burst abandons the transaction immediately. The AXI slave is reset in the same domain.
- AW/W/B outputs are registered or decoded from registered state only, with two exceptions: WDATA follows i_fifo_data and WVALID follows i_fifo_empty.
- No combinational path from any *READY to *VALID.
- Latency:
  - i_start to first AWVALID: 2 cycles when the FIFO is already holding ≥ BURST_LEN (IDLE→WAIT_FILL→ADDR).
  - AWREADY to first WVALID: 1 cycle.
  - Ideal slave: BURST_LEN+3 cycles per burst plus B latency.
- Once WAIT_FILL passes, the FIFO holds a full burst and this block is its only reader, so WVALID stays high through the burst. WVALID can therefore only stall on WREADY.
- AWVALID and WVALID stay asserted until their handshake (AXI stability rule). AWADDR, WDATA and WLAST hold stable while VALID && !READY.
- o_done rises the cycle after the final B handshake, together with o_busy falling.

## Test plan
- Basic command: DW=32, BURST_LEN=8, preload the FIFO with 16 words 0..15; start with base 0x1000, nbursts=2, ideal slave. Required:
  - AW addresses 0x1000 and 0x1020, AWLEN=7, AWSIZE=2.
  - W data 0..15, WLAST on beats 7 and 15.
  - One o_done pulse; o_err=0; FIFO empty at the end.
- Slow upstream: push 1 word every 3 cycles. Required: AWVALID never rises until fill ≥ 8, and no W beat is presented while the FIFO is empty.
- Backpressure: random AWREADY, WREADY and BVALID delays (0–5 cycles). Required: VALID and payload stay stable across every stall, and the data sequence is unchanged.
- Alignment and wrap: base 0xFFFF_FFF4 with AW=32, nbursts=2. Required: first AWADDR 0xFFFF_FFE0, second AWADDR 0x0000_0000.
- Response and degenerate cases:
  - BRESP=2'b10 on burst 1 of 3: all 3 bursts still complete, o_err=1 at o_done.
  - A new start clears o_err.
  - nbursts=0: o_done one cycle after start, with no AXI activity.
- Reset and ignored start:
  - Assert i_reset mid-DATA: all VALID/READY outputs and o_busy go low immediately.
  - After release: IDLE, and a new command runs correctly.
  - i_start while busy has no effect.
